// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester (core, DMA) and memory-side signals of mem_arbiter.
// slave is the arbiter's view; master is the view of whoever drives the
// requesters and models the memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // core port
  logic              i_c_req;
  logic              i_c_we;
  logic [ADDR_W-1:0] i_c_addr;
  logic [DATA_W-1:0] i_c_wdata;
  logic              o_c_gnt;
  logic              o_c_done;
  logic [DATA_W-1:0] o_c_rdata;
  // DMA / loader port
  logic              i_d_req;
  logic              i_d_we;
  logic [ADDR_W-1:0] i_d_addr;
  logic [DATA_W-1:0] i_d_wdata;
  logic              o_d_gnt;
  logic              o_d_done;
  logic [DATA_W-1:0] o_d_rdata;
  // memory side
  logic              o_m_en;
  logic              o_m_we;
  logic [ADDR_W-1:0] o_m_addr;
  logic [DATA_W-1:0] o_m_wdata;
  logic [DATA_W-1:0] i_m_rdata;

  modport slave (
    input  i_c_req, i_c_we, i_c_addr, i_c_wdata,
    input  i_d_req, i_d_we, i_d_addr, i_d_wdata,
    input  i_m_rdata,
    output o_c_gnt, o_c_done, o_c_rdata,
    output o_d_gnt, o_d_done, o_d_rdata,
    output o_m_en, o_m_we, o_m_addr, o_m_wdata
  );

  modport master (
    output i_c_req, i_c_we, i_c_addr, i_c_wdata,
    output i_d_req, i_d_we, i_d_addr, i_d_wdata,
    output i_m_rdata,
    input  o_c_gnt, o_c_done, o_c_rdata,
    input  o_d_gnt, o_d_done, o_d_rdata,
    input  o_m_en, o_m_we, o_m_addr, o_m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a core port and a DMA/loader port onto one
// fixed-latency memory (LAT cycles, 1..7). IDLE -> ACCESS (LAT cycles) -> DONE.
// Optional macro MEM_ARB_RR_EN: on simultaneous requests the port that lost the
// previous grant wins. Without it, priority is fixed and the core wins.
// Port index in the packed per-port arrays: 0 = core, 1 = DMA.

// Per-port read-data holder. During the DONE cycle of a read the memory data
// is passed straight through so it is visible together with done; the same
// value is latched at the end of that cycle and held until the next read.
module mem_arb_port #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_cap,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // load on a completing read, hold otherwise
  always_comb begin
    rdata_d = rdata_q;
    if (i_cap) rdata_d = i_rdata;
  end

  // read-data register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  assign o_rdata = i_cap ? i_rdata : rdata_q;
endmodule

module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 2
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  mem_arbiter_if.slave bus,
  output logic         o_busy
);
  localparam int         NP     = 2;
  localparam logic [2:0] LAT_M1 = 3'(LAT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [NP-1:0]             req, we, gnt, done, cap;
  logic [NP-1:0][ADDR_W-1:0] addr;
  logic [NP-1:0][DATA_W-1:0] wdata, rdata;
  logic                      pick, rr_pick;

  assign req   = {bus.i_d_req,   bus.i_c_req};
  assign we    = {bus.i_d_we,    bus.i_c_we};
  assign addr  = {bus.i_d_addr,  bus.i_c_addr};
  assign wdata = {bus.i_d_wdata, bus.i_c_wdata};

  // a lone requester wins; a tie goes to rr_pick
  assign pick = (req == 2'b10) ? 1'b1 : ((req == 2'b11) ? rr_pick : 1'b0);

`ifdef MEM_ARB_RR_EN
  logic ptr_q, ptr_d;

  // tie-break pointer: moves to the port that did not win, on every grant
  always_comb begin
    ptr_d = ptr_q;
    if (|gnt) ptr_d = ~pick;
  end

  // tie-break pointer register, starts on the core
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

  assign rr_pick = ptr_q;
`else
  assign rr_pick = 1'b0;
`endif

  // next-state, grant and request capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    gnt     = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          // gnt is combinational from req, so keep it quiet while in reset
          gnt[pick] = i_rstn;
          win_d     = pick;
          we_d      = we[pick];
          addr_d    = addr[pick];
          wdata_d   = wdata[pick];
          cnt_d     = LAT_M1;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 3'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state, counter and registered copy of the winning request
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign done = (state_q == DONE) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
  assign cap  = we_q ? 2'b00 : done;

  for (genvar p = 0; p < NP; p++) begin : g_port
    mem_arb_port #(.DATA_W(DATA_W)) u_port (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_cap   (cap[p]),
      .i_rdata (bus.i_m_rdata),
      .o_rdata (rdata[p])
    );
  end

  assign bus.o_c_gnt   = gnt[0];
  assign bus.o_d_gnt   = gnt[1];
  assign bus.o_c_done  = done[0];
  assign bus.o_d_done  = done[1];
  assign bus.o_c_rdata = rdata[0];
  assign bus.o_d_rdata = rdata[1];

  assign bus.o_m_en    = (state_q == ACCESS);
  assign bus.o_m_we    = (state_q == ACCESS) && we_q;
  assign bus.o_m_addr  = addr_q;
  assign bus.o_m_wdata = wdata_q;

  assign o_busy = (state_q != IDLE);
endmodule
